// File: rtl/scie_result_queue_if.sv
// Core-facing issue/writeback and SCIE-facing signals of the result queue.
// The master modport is the core/SCIE side and the slave modport is the queue itself.
interface scie_result_queue_if #(
    parameter int unsigned DEPTH = 4
);
    logic                      in_valid;
    logic [31:0]               in_insn;
    logic                      in_ready;
    logic                      sci_valid;
    logic signed [15:0]        sci_rd_real;
    logic signed [15:0]        sci_rd_imag;
    logic                      out_valid;
    logic                      out_ready;
    logic [4:0]                out_rd;
    logic [31:0]               out_data;
    logic [$clog2(DEPTH):0]    occupancy;

    modport master (
        output in_valid, in_insn, sci_rd_real, sci_rd_imag, out_ready,
        input  in_ready, sci_valid, out_valid, out_rd, out_data, occupancy
    );

    modport slave (
        input  in_valid, in_insn, sci_rd_real, sci_rd_imag, out_ready,
        output in_ready, sci_valid, out_valid, out_rd, out_data, occupancy
    );
endinterface

// File: rtl/scie_result_queue.sv
// Issue/writeback companion for the SCIEPipelined unit: a tag pipe that tracks in-flight issues
// and a credit-protected result FIFO of {rd, imag, real} entries.
module scie_result_queue #(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned DEPTH   = 4,
    parameter bit          DROP_X0 = 1'b1
) (
    input logic               clock,
    input logic               reset,
    scie_result_queue_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [LATENCY-1:0] tag_v_q, tag_v_d;
    logic [4:0]         tag_rd_q [LATENCY];
    logic [4:0]         tag_rd_d [LATENCY];

    logic [36:0]        mem_q [DEPTH];
    logic [36:0]        mem_d [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;

    logic [CW-1:0]      inflight;
    logic [CW:0]        total;
    logic               issue;
    logic               exit_v;
    logic [4:0]         exit_rd;
    logic               push;
    logic               pop;
    logic [36:0]        head;

    // Credit covers both queued and in-flight results, so a push can never find the FIFO full.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < LATENCY; i++) begin
            inflight = inflight + CW'(tag_v_q[i]);
        end
        total   = {1'b0, count_q} + {1'b0, inflight};
        issue   = bus.in_valid && (total < DEPTH_W);
        exit_v  = tag_v_q[LATENCY-1];
        exit_rd = tag_rd_q[LATENCY-1];
        push    = exit_v && !(DROP_X0 && (exit_rd == 5'd0));
        pop     = (count_q != '0) && bus.out_ready;
        head    = mem_q[rd_ptr_q];
    end

    always_comb begin
        tag_v_d     = tag_v_q;
        tag_rd_d    = tag_rd_q;
        tag_v_d[0]  = issue;
        tag_rd_d[0] = bus.in_insn[11:7];
        for (int unsigned i = 1; i < LATENCY; i++) begin
            tag_v_d[i]  = tag_v_q[i-1];
            tag_rd_d[i] = tag_rd_q[i-1];
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {exit_rd, bus.sci_rd_imag, bus.sci_rd_real};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_v_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                tag_rd_q[i] <= '0;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            tag_v_q  <= tag_v_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                tag_rd_q[i] <= tag_rd_d[i];
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    always_comb begin
        bus.in_ready  = (total < DEPTH_W);
        bus.sci_valid = issue;
        bus.out_valid = (count_q != '0);
        bus.out_rd    = head[36:32];
        bus.out_data  = head[31:0];
        bus.occupancy = total[CW-1:0];
    end
endmodule

// File: tb/tb_scie_result_queue.sv
// Directed bench for scie_result_queue with a queue-based reference model checked every cycle.
`timescale 1ns/1ps
module tb_scie_result_queue;
    localparam int unsigned LATENCY = 1;
    localparam int unsigned DEPTH   = 4;
    localparam bit          DROP_X0 = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   run = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    scie_result_queue_if #(.DEPTH(DEPTH)) bus ();

    scie_result_queue #(.LATENCY(LATENCY), .DEPTH(DEPTH), .DROP_X0(DROP_X0)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] rd; int rem; } tag_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; } res_t;
    tag_t pend[$];
    res_t mq[$];

    function automatic bit m_ready();
        return (mq.size() + pend.size()) < DEPTH;
    endfunction

    // Reference model: issued instructions wait LATENCY edges, then their result is queued.
    always @(posedge clk or posedge rst) begin
        bit   iss;
        bit   pp;
        tag_t t;
        if (rst) begin
            pend.delete();
            mq.delete();
        end else begin
            iss = bus.in_valid && m_ready();
            pp  = (mq.size() > 0) && bus.out_ready;
            if (pp) void'(mq.pop_front());
            foreach (pend[k]) pend[k].rem = pend[k].rem - 1;
            while (pend.size() > 0 && pend[0].rem == 0) begin
                t = pend.pop_front();
                if (!(DROP_X0 && t.rd == 5'd0))
                    mq.push_back('{t.rd, {bus.sci_rd_imag, bus.sci_rd_real}});
            end
            if (iss) pend.push_back('{bus.in_insn[11:7], LATENCY});
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run && !rst) begin
            chk("m_in_ready", 64'(bus.in_ready), 64'(m_ready()));
            chk("m_sci_valid", 64'(bus.sci_valid), 64'(bus.in_valid && m_ready()));
            chk("m_out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
            chk("m_occupancy", 64'(bus.occupancy), 64'(mq.size() + pend.size()));
            if (mq.size() > 0) begin
                chk("m_out_rd", 64'(bus.out_rd), 64'(mq[0].rd));
                chk("m_out_data", 64'(bus.out_data), 64'(mq[0].data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int rd, input int re, input int im);
        bus.in_valid    = v;
        bus.in_insn     = {20'h0, 5'(rd), 7'h0B};
        bus.sci_rd_real = 16'(re);
        bus.sci_rd_imag = 16'(im);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rd [4];
        bus.in_valid = 1'b0; bus.in_insn = '0; bus.out_ready = 1'b0;
        bus.sci_rd_real = '0; bus.sci_rd_imag = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_rd", 64'(bus.out_rd), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        run = 1'b1;

        // T1 single result
        drive(1'b1, 23, 0, 0);
        chk("t1_insn", 64'(bus.in_insn), 64'h0000_0B8B);
        chk("t1_sci_valid", 64'(bus.sci_valid), 64'd1);
        tick();
        drive(1'b0, 0, -31175, -5733);
        chk("t1_occ_inflight", 64'(bus.occupancy), 64'd1);
        chk("t1_no_bypass", 64'(bus.out_valid), 64'd0);
        tick();
        chk("t1_out_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_out_rd", 64'(bus.out_rd), 64'd23);
        chk("t1_out_data", 64'(bus.out_data), 64'hE99B_8639);
        bus.out_ready = 1'b1;
        tick();
        chk("t1_popped", 64'(bus.out_valid), 64'd0);
        chk("t1_occ_empty", 64'(bus.occupancy), 64'd0);
        bus.out_ready = 1'b0;

        // T2 x0 drop
        drive(1'b1, 0, 0, 0);
        tick();
        drive(1'b0, 0, 55, 66);
        chk("t2_occ1", 64'(bus.occupancy), 64'd1);
        tick();
        chk("t2_occ0", 64'(bus.occupancy), 64'd0);
        chk("t2_no_valid", 64'(bus.out_valid), 64'd0);
        tick();
        chk("t2_no_valid_late", 64'(bus.out_valid), 64'd0);

        // T3 backpressure: six back-to-back issues, only four accepted
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, i, (i - 1) * 100, i - 1);
            chk("t3_sci_valid", 64'(bus.sci_valid), 64'(i <= 4));
            tick();
        end
        drive(1'b0, 0, 0, 0);
        chk("t3_occ", 64'(bus.occupancy), 64'd4);
        chk("t3_in_ready", 64'(bus.in_ready), 64'd0);
        chk("t3_head_rd", 64'(bus.out_rd), 64'd1);
        chk("t3_head_data", 64'(bus.out_data), {32'h0, 16'd1, 16'd100});

        // T4 pop from full while attempting an issue
        bus.out_ready = 1'b1;
        drive(1'b1, 7, 0, 0);
        chk("t4_in_ready", 64'(bus.in_ready), 64'd0);
        chk("t4_sci_valid", 64'(bus.sci_valid), 64'd0);
        tick();
        bus.out_ready = 1'b0;
        drive(1'b1, 7, 0, 0);
        chk("t4_head_adv", 64'(bus.out_rd), 64'd2);
        chk("t4_occ3", 64'(bus.occupancy), 64'd3);
        chk("t4_reissue", 64'(bus.sci_valid), 64'd1);
        tick();
        drive(1'b0, 0, 700, 7);
        chk("t4_occ4", 64'(bus.occupancy), 64'd4);
        tick();
        chk("t4_head_stable", 64'(bus.out_rd), 64'd2);
        chk("t4_occ4_fifo", 64'(bus.occupancy), 64'd4);
        exp_rd = '{2, 3, 4, 7};
        bus.out_ready = 1'b1;
        foreach (exp_rd[k]) begin
            #1;
            chk("t4_drain_rd", 64'(bus.out_rd), 64'(exp_rd[k]));
            tick();
        end
        chk("t4_drained", 64'(bus.out_valid), 64'd0);

        // T5 streaming at one issue per cycle
        for (int i = 1; i <= 18; i++) begin
            drive(1'b1 && (i <= 16), i, i - 1, -(i - 1));
            if (i <= 16) chk("t5_in_ready", 64'(bus.in_ready), 64'd1);
            if (i >= 3) begin
                chk("t5_out_rd", 64'(bus.out_rd), 64'(i - 2));
                chk("t5_out_data", 64'(bus.out_data), {32'h0, 16'(-(i - 2)), 16'(i - 2)});
            end
            tick();
        end
        drive(1'b0, 0, 0, 0);
        tick();
        chk("t5_empty", 64'(bus.occupancy), 64'd0);
        bus.out_ready = 1'b0;

        // T6 asynchronous reset with two queued and one in flight
        drive(1'b1, 9, 0, 0);
        tick();
        drive(1'b1, 10, 9, 9);
        tick();
        drive(1'b1, 11, 10, 10);
        tick();
        drive(1'b0, 0, 11, 11);
        chk("t6_occ_before", 64'(bus.occupancy), 64'd3);
        rst = 1'b1;
        #1;
        chk("t6_async_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_async_occ", 64'(bus.occupancy), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_replay", 64'(bus.out_valid), 64'd0);
            chk("t6_occ_zero", 64'(bus.occupancy), 64'd0);
        end
        chk("t6_in_ready", 64'(bus.in_ready), 64'd1);

        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
